// File: rtl/bikelight_pkg.sv
// Shared definitions for the bike-light controller: mode encoding and helpers.
package bikelight_pkg;

   localparam int unsigned NUM_MODES = 5;

   // Mode codes; codes 5-7 are never produced.
   typedef enum logic [2:0] {
      MODE_OFF   = 3'd0,
      MODE_ON    = 3'd1,
      MODE_BLINK = 3'd2,
      MODE_DIM   = 3'd3,
      MODE_CHASE = 3'd4
   } mode_e;

   // Short-press sequence OFF -> ON -> BLINK -> DIM -> CHASE -> OFF.
   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      case (m)
         MODE_OFF:   n = MODE_ON;
         MODE_ON:    n = MODE_BLINK;
         MODE_BLINK: n = MODE_DIM;
         MODE_DIM:   n = MODE_CHASE;
         default:    n = MODE_OFF;
      endcase
      return n;
   endfunction

   // One-hot status: bit i set for mode code i.
   function automatic logic [NUM_MODES-1:0] mode_to_onehot(input mode_e m);
      logic [NUM_MODES-1:0] oh;
      oh = '0;
      case (m)
         MODE_OFF:   oh[0] = 1'b1;
         MODE_ON:    oh[1] = 1'b1;
         MODE_BLINK: oh[2] = 1'b1;
         MODE_DIM:   oh[3] = 1'b1;
         MODE_CHASE: oh[4] = 1'b1;
         default:    oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button front end: 2-flop synchroniser, counting debouncer and a
// one-cycle press pulse on each accepted rising level.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          btn_s;
   logic          db_q, db_d;
   logic          db_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;

   assign btn_s = sync_q[1];

   // Count consecutive edges where the synchronised input disagrees with db.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (btn_s != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = btn_s;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Synchroniser, debounce state and one-cycle delay of db.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], btn};
         db_q     <= db_d;
         db_dly_q <= db_q;
         cnt_q    <= cnt_d;
      end
   end

   assign level = db_q;
   assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/bikelight_multi.sv
// Multi-channel bike-light controller. One debounced button cycles a shared
// mode (OFF/ON/BLINK/DIM/CHASE) across CHANNELS registered lamp outputs.
// Optional: define BIKELIGHT_LONG_PRESS_OFF_EN to force OFF after a long hold.
module bikelight_multi
   import bikelight_pkg::*;
#(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned BLINK_HALF      = 12500000,
   parameter int unsigned PWM_W           = 8,
   parameter int unsigned DIM_DUTY        = 32
`ifdef BIKELIGHT_LONG_PRESS_OFF_EN
   ,
   parameter int unsigned LONG_CYCLES     = 50000000
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 btn,
   output logic [CHANNELS-1:0]  light,
   output logic [NUM_MODES-1:0] mode_onehot,
   output logic [2:0]           mode_code
);

   localparam int unsigned PW  = $clog2(BLINK_HALF);
   localparam int unsigned CHW = $clog2(CHANNELS);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(BLINK_HALF - 1);
   localparam logic [CHW-1:0]   CHASE_LAST = CHW'(CHANNELS - 1);
   localparam logic [PWM_W-1:0] DUTY       = PWM_W'(DIM_DUTY);

   logic          db_level;
   logic          press;
   logic          long_evt;
   logic          mode_chg;

   mode_e         mode_q, mode_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          phase_q, phase_d;
   logic [CHW-1:0] chase_q, chase_d;
   logic [PWM_W-1:0] pwm_q, pwm_d;
   logic [CHANNELS-1:0] light_q, light_d;

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn),
      .level (db_level),
      .press (press)
   );

`ifdef BIKELIGHT_LONG_PRESS_OFF_EN
   localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

   logic [LW-1:0] hold_q, hold_d;

   // Hold counter saturates at LONG_CYCLES so the forced OFF fires once per hold.
   always_comb begin
      hold_d = '0;
      if (db_level) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + LW'(1);
      end
   end

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign long_evt = db_level && (hold_q == HOLD_LAST);
`else
   logic unused_db_level;
   assign unused_db_level = db_level;
   assign long_evt        = 1'b0;
`endif

   assign mode_chg = press | long_evt;

   // Mode sequencing and timing state; a mode change restarts all timing lit.
   always_comb begin
      mode_d  = mode_q;
      presc_d = presc_q;
      phase_d = phase_q;
      chase_d = chase_q;
      pwm_d   = pwm_q;
      if (press) begin
         mode_d = next_mode(mode_q);
      end
      if (long_evt) begin
         mode_d = MODE_OFF;
      end
      if (mode_chg) begin
         presc_d = '0;
         phase_d = 1'b1;
         chase_d = '0;
         pwm_d   = '0;
      end else begin
         pwm_d = pwm_q + PWM_W'(1);
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
            chase_d = (chase_q == CHASE_LAST) ? '0 : chase_q + CHW'(1);
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Per-mode lamp pattern, registered below.
   always_comb begin
      light_d = '0;
      case (mode_q)
         MODE_OFF:   light_d = '0;
         MODE_ON:    light_d = '1;
         MODE_BLINK: light_d = {CHANNELS{phase_q}};
         MODE_DIM:   light_d = {CHANNELS{pwm_q < DUTY}};
         MODE_CHASE: light_d = CHANNELS'(1) << chase_q;
         default:    light_d = '0;
      endcase
   end

   // Mode, timing and lamp registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q  <= MODE_OFF;
         presc_q <= '0;
         phase_q <= 1'b0;
         chase_q <= '0;
         pwm_q   <= '0;
         light_q <= '0;
      end else begin
         mode_q  <= mode_d;
         presc_q <= presc_d;
         phase_q <= phase_d;
         chase_q <= chase_d;
         pwm_q   <= pwm_d;
         light_q <= light_d;
      end
   end

   assign light       = light_q;
   assign mode_code   = mode_q;
   assign mode_onehot = mode_to_onehot(mode_q);

endmodule

// File: tb/tb_bikelight_multi.sv
// Directed bench for bikelight_multi with small timing parameters.
module tb_bikelight_multi;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn = 1'b0;
   logic [3:0] light;
   logic [4:0] mode_onehot;
   logic [2:0] mode_code;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bikelight_multi #(
      .CHANNELS        (4),
      .DEBOUNCE_CYCLES (4),
      .BLINK_HALF      (5),
      .PWM_W           (4),
      .DIM_DUTY        (3)
`ifdef BIKELIGHT_LONG_PRESS_OFF_EN
      ,
      .LONG_CYCLES     (20)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn),
      .light       (light),
      .mode_onehot (mode_onehot),
      .mode_code   (mode_code)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_mode(input string tag, input logic [2:0] code);
      logic [4:0] oh;
      oh = 5'b00001 << code;
      check({tag, "_code"}, {29'd0, mode_code}, {29'd0, code});
      check({tag, "_onehot"}, {27'd0, mode_onehot}, {27'd0, oh});
   endtask

   // Raise btn; mode must move from prev to next exactly 7 edges later.
   task automatic press_to(input logic [2:0] prev, input logic [2:0] next);
      btn = 1'b1;
      repeat (6) tick();
      check("pre_press", {29'd0, mode_code}, {29'd0, prev});
      tick();
      check_mode("press", next);
      btn = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_l;

      // Reset state
      repeat (2) tick();
      check_mode("reset", 3'd0);
      check("reset_light", {28'd0, light}, 32'h0);
      reset = 1'b0;

      // Glitch of 3 cycles must not register
      btn = 1'b1;
      repeat (3) tick();
      btn = 1'b0;
      repeat (20) tick();
      check("glitch", {29'd0, mode_code}, 32'd0);

      // Clean press, held: OFF -> ON at edge 7, light at edge 8, only one press
      btn = 1'b1;
      repeat (6) tick();
      check("lat_edge6", {29'd0, mode_code}, 32'd0);
      tick();
      check_mode("lat_edge7", 3'd1);
      check("light_edge7", {28'd0, light}, 32'h0);
      tick();
      check("light_edge8", {28'd0, light}, 32'hF);
      repeat (10) tick();
      check("hold_once", {29'd0, mode_code}, 32'd1);
      btn = 1'b0;
      repeat (20) tick();
      check("release", {29'd0, mode_code}, 32'd1);

      // BLINK: 5 lit, 5 dark
      press_to(3'd1, 3'd2);
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp_l = (((i - 1) / 5) % 2 == 0) ? 4'hF : 4'h0;
         check("blink", {28'd0, light}, {28'd0, exp_l});
      end

      // DIM: 3 lit of every 16, starting first cycle
      press_to(3'd2, 3'd3);
      for (int i = 1; i <= 32; i++) begin
         tick();
         exp_l = (((i - 1) % 16) < 3) ? 4'hF : 4'h0;
         check("dim", {28'd0, light}, {28'd0, exp_l});
      end

      // CHASE: walking one, 5 cycles per step
      press_to(3'd3, 3'd4);
      for (int i = 1; i <= 25; i++) begin
         tick();
         exp_l = 4'b0001 << (((i - 1) / 5) % 4);
         check("chase", {28'd0, light}, {28'd0, exp_l});
      end

      // Wrap CHASE -> OFF
      press_to(3'd4, 3'd0);
      tick();
      check("off_light", {28'd0, light}, 32'h0);
      repeat (20) tick();

      // Reset mid-BLINK
      press_to(3'd0, 3'd1);
      repeat (20) tick();
      press_to(3'd1, 3'd2);
      repeat (3) tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_mode("rst_mid", 3'd0);
         check("rst_mid_light", {28'd0, light}, 32'h0);
      end
      reset = 1'b0;
      repeat (2) tick();
      check("post_rst", {29'd0, mode_code}, 32'd0);
      repeat (20) tick();

`ifdef BIKELIGHT_LONG_PRESS_OFF_EN
      // Long hold from DIM: CHASE at edge 7, forced OFF at edge 26
      press_to(3'd0, 3'd1);
      repeat (20) tick();
      press_to(3'd1, 3'd2);
      repeat (20) tick();
      press_to(3'd2, 3'd3);
      repeat (20) tick();
      btn = 1'b1;
      repeat (7) tick();
      check_mode("long_chase", 3'd4);
      repeat (18) tick();
      check("long_pre", {29'd0, mode_code}, 32'd4);
      tick();
      check_mode("long_off", 3'd0);
      tick();
      check("long_light", {28'd0, light}, 32'h0);
      repeat (13) tick();
      btn = 1'b0;
      repeat (20) tick();
      check("long_release", {29'd0, mode_code}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
